vx_conv_issue: RTL and testbench
================================

Name: vx_conv_issue

Overview:
- Upstream neighbour of the conv execute unit. Accepts per-warp conv beats from dispatch and buffers them in an in-order FIFO.
- Issues beats to the conv unit as fixed-size dot-product groups of BEATS beats. The conv accumulator emits one result per BEATS accepted beats.
- Enforces group integrity and a credit limit on groups whose results have not yet been committed.
- Zeroes rs1 lanes for inactive threads, so masked lanes add 0 to the adder tree.

Parameters:
- CORE_ID, 0, core index (debug only).
- DEPTH, 4, FIFO entries (power of 2, >= 2).
- BEATS, `NUM_THREADS, beats per dot-product group; must equal the conv accumulator N.
- MAX_GROUPS, 2, groups issued but not yet committed (1..7).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- conv_disp_if_valid  in  1  dispatch beat valid.
- conv_disp_if_ready  out  1  beat accepted when valid&ready.
- conv_disp_if_uuid  in  `UUID_BITS  instruction uuid.
- conv_disp_if_wid  in  `NW_BITS  warp id.
- conv_disp_if_tmask  in  `NUM_THREADS  thread mask.
- conv_disp_if_PC  in  32  PC.
- conv_disp_if_rs1_data  in  `NUM_THREADS*32  operand A lanes.
- conv_disp_if_rs2_data  in  `NUM_THREADS*32  operand B lanes.
- conv_disp_if_rd  in  `NR_BITS  destination register.
- conv_disp_if_wb  in  1  writeback enable.
- conv_req_if_valid/uuid/wid/tmask/PC/rs1_data/rs2_data/rd/wb  out  same widths  to conv unit.
- conv_req_if_ready  in  1  conv unit accepts.
- conv_commit_fire  in  1  conv_commit_if_valid & conv_commit_if_ready (one group retired).
- credits  out  3  groups outstanding.
- beat_idx  out  clog2(BEATS)  index of next beat in current group.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset==0 at clk edge):
  - FIFO emptied; credits=0; beat_idx=0; state=IDLE; err=0.
  - conv_req_if_valid=0; conv_disp_if_ready=0 while in reset.
  - Reset mid-group discards all buffered beats.
- FIFO:
  - Registered, no bypass. A beat written in cycle t is visible on conv_req_if_* at t+1 at the earliest.
  - conv_disp_if_ready = !full. When full, a simultaneous push and pop is not allowed (ready=0).
  - When empty, a simultaneous push and pop means the pop is idle.
- Masking at FIFO write: rs1 lane i = 0 when tmask[i]==0; rs2 is passed through unchanged.
- States:
  - IDLE: beat_idx==0. BURST: beat_idx!=0. BLOCK: IDLE and credits==MAX_GROUPS.
  - conv_req_if_valid = !empty && (state==BURST || credits<MAX_GROUPS).
  - A group already started is never blocked by credits.
- Issue fire = conv_req_if_valid & conv_req_if_ready.
  - On fire: pop FIFO; beat_idx increments.
  - At BEATS-1, beat_idx wraps to 0 and credits increments (group complete).
- conv_commit_fire decrements credits.
  - Group completion and commit in the same cycle: credits unchanged.
  - Commit with credits==0: credits stays 0, err set.
- Group integrity:
  - Beat 0's wid is latched. A later beat of the same group with a different wid sets err; the beat is still issued.
- err clears only on reset.
- All outputs other than ready are registered or taken directly from FIFO storage. No combinational path from conv_req_if_ready to conv_disp_if_ready.

Decomposition:
- Shared package: CONV_CREDIT_W=3, an entry-width constant, and a localparam for the lane-mask function.
- One sub-module: vx_conv_issue_fifo, a generic DATAW/DEPTH synchronous FIFO with full/empty/count, active-low sync reset.
- The top level holds the masking logic, the beat counter, the credit counter and err.

Test Plan (NUM_THREADS=4, BEATS=4, DEPTH=4, MAX_GROUPS=2):
- Push 4 beats, wid=1, tmask=4'hF, rs1 lanes=1,2,3,4, conv_req_if_ready=1 -> valid from the cycle after the first push; 4 fires; beat_idx 0,1,2,3,0; credits=1 after the 4th fire.
- tmask=4'b0101, rs1 lanes=all 7 -> conv_req_if_rs1_data lanes = 7,0,7,0; rs2 unchanged.
- 3 groups queued, no commits -> after 8 fires credits=2 and valid=0 (BLOCK); pulse conv_commit_fire -> credits=1, valid=1 next cycle.
- Group completion and conv_commit_fire in the same cycle with credits=1 -> credits stays 1, err=0.
- conv_commit_fire with credits=0 -> err=1, credits=0; err persists until reset. Separately, beat 2 of a group carries wid=3 after beat 0 wid=1 -> err=1, beat issued.
- Fill FIFO with conv_req_if_ready=0 -> conv_disp_if_ready=0 after 4 pushes. Then assert reset low mid-group (beat_idx=2) -> next cycle valid=0, credits=0, beat_idx=0, FIFO empty, ready=1 after release.

Source files
------------

// File: rtl/vx_conv_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_conv_issue_pkg
// Description : Shared types and constants for the conv issue stage: the
//               buffered beat layout, the issue state encoding and the
//               inactive-lane zeroing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_conv_issue_pkg;

  // Core-wide widths seen by the conv datapath.
  localparam int NUM_THREADS   = 4;
  localparam int UUID_BITS     = 44;
  localparam int NW_BITS       = 2;
  localparam int NR_BITS       = 5;

  // Width of one operand lane, used by the lane-mask helper.
  localparam int LANE_W        = 32;

  // Outstanding-group counter width (supports up to 7 groups).
  localparam int CONV_CREDIT_W = 3;

  // One buffered beat as held in the FIFO.
  typedef struct packed {
    logic [UUID_BITS-1:0]          uuid;
    logic [NW_BITS-1:0]            wid;
    logic [NUM_THREADS-1:0]        tmask;
    logic [31:0]                   pc;
    logic [NUM_THREADS*LANE_W-1:0] rs1;
    logic [NUM_THREADS*LANE_W-1:0] rs2;
    logic [NR_BITS-1:0]            rd;
    logic                          wb;
  } conv_entry_t;

  localparam int CONV_ENTRY_W = $bits(conv_entry_t);

  // IDLE: at a group boundary; BURST: inside a group; BLOCK: at a group
  // boundary with every credit in use.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_BLOCK = 2'd2
  } conv_state_e;

  // Zero every lane whose thread is inactive so it contributes 0 to the
  // accumulator's adder tree.
  function automatic logic [NUM_THREADS*LANE_W-1:0] mask_lanes(
    input logic [NUM_THREADS*LANE_W-1:0] data,
    input logic [NUM_THREADS-1:0]        tmask
  );
    logic [NUM_THREADS*LANE_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (tmask[i]) begin
        res[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_conv_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vx_conv_issue_fifo
// Description : Generic registered synchronous FIFO, no bypass. Read data is
//               taken straight from storage at the read pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_conv_issue_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,     // synchronous, active-low
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATAW-1:0]       data_i,
  output logic [DATAW-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATAW-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              w_push, w_pop;

  // Guard against overflow/underflow; callers normally never violate these.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vx_conv_issue.sv
`default_nettype none
// ============================================================================
// Module      : vx_conv_issue
// Description : Buffers dispatch conv beats, zeroes inactive rs1 lanes, and
//               issues them to the conv unit in BEATS-beat groups under a
//               credit limit on uncommitted groups. Flags protocol errors.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_conv_issue
  import vx_conv_issue_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int DEPTH      = 4,
  parameter int BEATS      = NUM_THREADS,   // must be >= 2
  parameter int MAX_GROUPS = 2
) (
  input  logic                          clk,
  input  logic                          reset,   // synchronous, active-low

  input  logic                          conv_disp_if_valid,
  output logic                          conv_disp_if_ready,
  input  logic [UUID_BITS-1:0]          conv_disp_if_uuid,
  input  logic [NW_BITS-1:0]            conv_disp_if_wid,
  input  logic [NUM_THREADS-1:0]        conv_disp_if_tmask,
  input  logic [31:0]                   conv_disp_if_PC,
  input  logic [NUM_THREADS*LANE_W-1:0] conv_disp_if_rs1_data,
  input  logic [NUM_THREADS*LANE_W-1:0] conv_disp_if_rs2_data,
  input  logic [NR_BITS-1:0]            conv_disp_if_rd,
  input  logic                          conv_disp_if_wb,

  output logic                          conv_req_if_valid,
  output logic [UUID_BITS-1:0]          conv_req_if_uuid,
  output logic [NW_BITS-1:0]            conv_req_if_wid,
  output logic [NUM_THREADS-1:0]        conv_req_if_tmask,
  output logic [31:0]                   conv_req_if_PC,
  output logic [NUM_THREADS*LANE_W-1:0] conv_req_if_rs1_data,
  output logic [NUM_THREADS*LANE_W-1:0] conv_req_if_rs2_data,
  output logic [NR_BITS-1:0]            conv_req_if_rd,
  output logic                          conv_req_if_wb,
  input  logic                          conv_req_if_ready,

  input  logic                          conv_commit_fire,
  output logic [CONV_CREDIT_W-1:0]      credits,
  output logic [$clog2(BEATS)-1:0]      beat_idx,
  output logic                          err
);

  localparam int BIDX_W = $clog2(BEATS);
  localparam logic [BIDX_W-1:0]        C_LAST_BEAT = BIDX_W'(BEATS - 1);
  localparam logic [CONV_CREDIT_W-1:0] C_MAX_CRED  = CONV_CREDIT_W'(MAX_GROUPS);

  // Elaboration-time sanity on parameters.
  if (CORE_ID < 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BEATS < 2 ||
      MAX_GROUPS < 1 || MAX_GROUPS > 7) begin : g_bad_params
    $error("vx_conv_issue: illegal parameter combination");
  end

  conv_entry_t              w_wr_entry, w_rd_entry;
  logic                     w_push, w_pop, w_full, w_empty, w_grp_done;
  logic [$clog2(DEPTH):0]   w_fifo_count_unused;

  conv_state_e              state_q, state_d;
  logic [BIDX_W-1:0]        beat_idx_q, beat_idx_d;
  logic [CONV_CREDIT_W-1:0] credits_q, credits_d;
  logic [NW_BITS-1:0]       grp_wid_q, grp_wid_d;
  logic                     err_q, err_d;

  assign w_wr_entry = '{
    uuid:  conv_disp_if_uuid,
    wid:   conv_disp_if_wid,
    tmask: conv_disp_if_tmask,
    pc:    conv_disp_if_PC,
    rs1:   mask_lanes(conv_disp_if_rs1_data, conv_disp_if_tmask),
    rs2:   conv_disp_if_rs2_data,
    rd:    conv_disp_if_rd,
    wb:    conv_disp_if_wb
  };

  // Ready depends only on FIFO occupancy and reset, never on conv_req_if_ready.
  assign conv_disp_if_ready = reset && !w_full;
  assign w_push             = conv_disp_if_valid && conv_disp_if_ready;

  // An open group always drains; a new group needs a free credit.
  assign conv_req_if_valid  = !w_empty && ((state_q == ST_BURST) || (credits_q < C_MAX_CRED));
  assign w_pop              = conv_req_if_valid && conv_req_if_ready;

  vx_conv_issue_fifo #(
    .DATAW (CONV_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_wr_entry),
    .data_o  (w_rd_entry),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_fifo_count_unused)
  );

  assign conv_req_if_uuid     = w_rd_entry.uuid;
  assign conv_req_if_wid      = w_rd_entry.wid;
  assign conv_req_if_tmask    = w_rd_entry.tmask;
  assign conv_req_if_PC       = w_rd_entry.pc;
  assign conv_req_if_rs1_data = w_rd_entry.rs1;
  assign conv_req_if_rs2_data = w_rd_entry.rs2;
  assign conv_req_if_rd       = w_rd_entry.rd;
  assign conv_req_if_wb       = w_rd_entry.wb;

  assign credits  = credits_q;
  assign beat_idx = beat_idx_q;
  assign err      = err_q;

  // Next state: beat counter, group wid check, credit accounting, state.
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    credits_d  = credits_q;
    grp_wid_d  = grp_wid_q;
    err_d      = err_q;
    w_grp_done = w_pop && (beat_idx_q == C_LAST_BEAT);

    if (w_pop) begin
      if (beat_idx_q == '0) begin
        grp_wid_d = w_rd_entry.wid;
      end else if (w_rd_entry.wid != grp_wid_q) begin
        err_d = 1'b1;       // group mixes warps; the beat still goes out
      end
      beat_idx_d = w_grp_done ? '0 : beat_idx_q + BIDX_W'(1);
    end

    case ({w_grp_done, conv_commit_fire})
      2'b10: credits_d = credits_q + CONV_CREDIT_W'(1);
      2'b01: begin
        if (credits_q == '0) err_d = 1'b1;   // commit with nothing outstanding
        else                 credits_d = credits_q - CONV_CREDIT_W'(1);
      end
      default: credits_d = credits_q;        // none, or completion cancels commit
    endcase

    if (beat_idx_d != '0)            state_d = ST_BURST;
    else if (credits_d == C_MAX_CRED) state_d = ST_BLOCK;
    else                             state_d = ST_IDLE;
  end

  // State registers; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      beat_idx_q <= '0;
      credits_q  <= '0;
      grp_wid_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      credits_q  <= credits_d;
      grp_wid_q  <= grp_wid_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vx_conv_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_conv_issue
// Description : Directed self-checking bench for vx_conv_issue
//               (NUM_THREADS=4, BEATS=4, DEPTH=4, MAX_GROUPS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_conv_issue;
  import vx_conv_issue_pkg::*;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          disp_valid, disp_ready;
  logic [UUID_BITS-1:0]          disp_uuid;
  logic [NW_BITS-1:0]            disp_wid;
  logic [NUM_THREADS-1:0]        disp_tmask;
  logic [31:0]                   disp_pc;
  logic [NUM_THREADS*LANE_W-1:0] disp_rs1, disp_rs2;
  logic [NR_BITS-1:0]            disp_rd;
  logic                          disp_wb;
  logic                          req_valid, req_ready;
  logic [UUID_BITS-1:0]          req_uuid;
  logic [NW_BITS-1:0]            req_wid;
  logic [NUM_THREADS-1:0]        req_tmask;
  logic [31:0]                   req_pc;
  logic [NUM_THREADS*LANE_W-1:0] req_rs1, req_rs2;
  logic [NR_BITS-1:0]            req_rd;
  logic                          req_wb;
  logic                          commit;
  logic [2:0]                    credits;
  logic [1:0]                    beat_idx;
  logic                          err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] L1234 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] L7777 = {32'd7, 32'd7, 32'd7, 32'd7};
  localparam logic [127:0] RS2A  = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};

  vx_conv_issue #(
    .CORE_ID    (0),
    .DEPTH      (4),
    .BEATS      (4),
    .MAX_GROUPS (2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .conv_disp_if_valid    (disp_valid),
    .conv_disp_if_ready    (disp_ready),
    .conv_disp_if_uuid     (disp_uuid),
    .conv_disp_if_wid      (disp_wid),
    .conv_disp_if_tmask    (disp_tmask),
    .conv_disp_if_PC       (disp_pc),
    .conv_disp_if_rs1_data (disp_rs1),
    .conv_disp_if_rs2_data (disp_rs2),
    .conv_disp_if_rd       (disp_rd),
    .conv_disp_if_wb       (disp_wb),
    .conv_req_if_valid     (req_valid),
    .conv_req_if_uuid      (req_uuid),
    .conv_req_if_wid       (req_wid),
    .conv_req_if_tmask     (req_tmask),
    .conv_req_if_PC        (req_pc),
    .conv_req_if_rs1_data  (req_rs1),
    .conv_req_if_rs2_data  (req_rs2),
    .conv_req_if_rd        (req_rd),
    .conv_req_if_wb        (req_wb),
    .conv_req_if_ready     (req_ready),
    .conv_commit_fire      (commit),
    .credits               (credits),
    .beat_idx              (beat_idx),
    .err                   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; returns just after the edge where it was accepted.
  task automatic push_beat(input logic [NW_BITS-1:0] wid, input logic [3:0] tmask,
                           input logic [127:0] rs1, input logic [127:0] rs2);
    bit ok;
    ok         = 1'b0;
    disp_valid = 1'b1;
    disp_wid   = wid;
    disp_tmask = tmask;
    disp_rs1   = rs1;
    disp_rs2   = rs2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (disp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    disp_valid = 1'b0;
    check("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    disp_valid = 1'b0;
    disp_uuid  = 44'h123_4567_89AB;
    disp_wid   = '0;
    disp_tmask = '0;
    disp_pc    = 32'h0000_1000;
    disp_rs1   = '0;
    disp_rs2   = '0;
    disp_rd    = 5'd9;
    disp_wb    = 1'b1;
    req_ready  = 1'b0;
    commit     = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid",    64'(req_valid),  64'd0);
    check("rst_ready",    64'(disp_ready), 64'd0);
    check("rst_credits",  64'(credits),    64'd0);
    check("rst_beat_idx", 64'(beat_idx),   64'd0);
    check("rst_err",      64'(err),        64'd0);
    reset = 1'b1;
    #1;
    check("ready_after_rst", 64'(disp_ready), 64'd1);

    // One full group with the conv unit always ready
    req_ready = 1'b1;
    push_beat(2'd1, 4'hF, L1234, RS2A);
    check("g1_valid",    64'(req_valid),      64'd1);
    check("g1_idx0",     64'(beat_idx),       64'd0);
    check("g1_lane0",    64'(req_rs1[31:0]),  64'd1);
    check("g1_lane3",    64'(req_rs1[127:96]),64'd4);
    check("g1_wid",      64'(req_wid),        64'd1);
    check("g1_pc",       64'(req_pc),         64'h1000);
    check("g1_uuid",     64'(req_uuid),       64'h123_4567_89AB);
    push_beat(2'd1, 4'hF, L1234, RS2A);
    check("g1_idx1",     64'(beat_idx),       64'd1);
    push_beat(2'd1, 4'hF, L1234, RS2A);
    check("g1_idx2",     64'(beat_idx),       64'd2);
    push_beat(2'd1, 4'hF, L1234, RS2A);
    check("g1_idx3",     64'(beat_idx),       64'd3);
    check("g1_cred_mid", 64'(credits),        64'd0);
    tick();
    check("g1_idx_wrap", 64'(beat_idx),       64'd0);
    check("g1_credits",  64'(credits),        64'd1);
    check("g1_drained",  64'(req_valid),      64'd0);
    pulse_commit();
    check("g1_commit",   64'(credits),        64'd0);
    check("g1_err",      64'(err),            64'd0);

    // Lane masking, FIFO fill, then reset mid-group
    req_ready = 1'b0;
    push_beat(2'd1, 4'b0101, L7777, RS2A);
    check("mask_lane0",  64'(req_rs1[31:0]),   64'd7);
    check("mask_lane1",  64'(req_rs1[63:32]),  64'd0);
    check("mask_lane2",  64'(req_rs1[95:64]),  64'd7);
    check("mask_lane3",  64'(req_rs1[127:96]), 64'd0);
    check("mask_rs2_lo", req_rs2[63:0],        RS2A[63:0]);
    check("mask_rs2_hi", req_rs2[127:64],      RS2A[127:64]);
    check("mask_tmask",  64'(req_tmask),       64'h5);
    for (int i = 0; i < 3; i++) push_beat(2'd1, 4'hF, L1234, RS2A);
    check("full_ready",  64'(disp_ready),      64'd0);
    req_ready = 1'b1;
    tick(); tick();
    check("mid_idx2",    64'(beat_idx),        64'd2);
    reset = 1'b0;
    tick();
    check("mrst_valid",  64'(req_valid),       64'd0);
    check("mrst_credit", 64'(credits),         64'd0);
    check("mrst_idx",    64'(beat_idx),        64'd0);
    check("mrst_ready",  64'(disp_ready),      64'd0);
    reset = 1'b1;
    #1;
    check("mrst_rel_rdy",64'(disp_ready),      64'd1);
    tick();
    check("mrst_empty",  64'(req_valid),       64'd0);

    // Three groups queued, no commits: blocks at MAX_GROUPS
    for (int i = 0; i < 12; i++) push_beat(2'd2, 4'hF, L1234, RS2A);
    check("blk_credits", 64'(credits),         64'd2);
    check("blk_valid",   64'(req_valid),       64'd0);
    check("blk_idx",     64'(beat_idx),        64'd0);
    check("blk_full",    64'(disp_ready),      64'd0);
    pulse_commit();
    check("unblk_cred",  64'(credits),         64'd1);
    check("unblk_valid", 64'(req_valid),       64'd1);
    tick(); tick(); tick();
    check("g3_idx3",     64'(beat_idx),        64'd3);
    check("g3_cred",     64'(credits),         64'd1);
    // Group completes in the same cycle a commit arrives
    pulse_commit();
    check("same_cred",   64'(credits),         64'd1);
    check("same_err",    64'(err),             64'd0);
    check("same_idx",    64'(beat_idx),        64'd0);
    pulse_commit();
    check("drain_cred",  64'(credits),         64'd0);

    // Commit with no outstanding group
    pulse_commit();
    check("uflow_err",   64'(err),             64'd1);
    check("uflow_cred",  64'(credits),         64'd0);
    tick(); tick(); tick();
    check("err_sticky",  64'(err),             64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("err_cleared", 64'(err),             64'd0);

    // Warp id changes inside a group
    push_beat(2'd1, 4'hF, L1234, RS2A);
    push_beat(2'd1, 4'hF, L1234, RS2A);
    push_beat(2'd3, 4'hF, L1234, RS2A);
    check("wid_head",    64'(req_wid),         64'd3);
    check("wid_err_pre", 64'(err),             64'd0);
    push_beat(2'd1, 4'hF, L1234, RS2A);
    check("wid_err",     64'(err),             64'd1);
    check("wid_issued",  64'(beat_idx),        64'd3);
    tick();
    check("wid_grp_end", 64'(credits),         64'd1);
    check("wid_idx0",    64'(beat_idx),        64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
